// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and constants for the multiply/divide sequencer:
//             FSM state encoding, HI/LO source select values, default run
//             lengths and the cycle-counter width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        COMMIT   = 3'd3,
        DZERO    = 3'd4
    } state_t;

    // HI/LO mux select values
    localparam logic SRC_MULT = 1'b0;
    localparam logic SRC_DIV  = 1'b1;

    localparam int DEFAULT_MULT_CYCLES = 32;
    localparam int DEFAULT_DIV_CYCLES  = 32;

    // Counter holds N-1 at most, so clog2 of the longest run suffices;
    // never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module   : op_cycle_counter
//  Purpose  : Loadable down-counter that times one multiply/divide run.
//             Saturates at zero (never wraps) and flags the zero count.
//  Ports    : clk          - clock
//             rst          - asynchronous active-high reset (count -> 0)
//             i_load       - load i_load_value (priority over decrement)
//             i_load_value - value to load
//             i_dec        - decrement by one when non-zero
//             o_zero       - count is zero
//  Revision : 1.0  initial release
// ============================================================================
module op_cycle_counter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Sequences the shared Mult/Div unit: runs the selected unit for
//             a fixed cycle count, then commits into HI/LO. A divide with a
//             zero divisor is rejected up front and reported via Div_Zero.
//  Ports    : Clock, Reset           - clock, async active-high reset
//             Start_Mult, Start_Div  - one-cycle start requests (IDLE only)
//             Divisor[31:0]          - B value, sampled with Start_Div
//             Abort                  - flush any operation in progress
//             Mult_Control           - Mult unit run level
//             Div_Control            - Div unit run level
//             HI_Src, LO_Src         - HI/LO source (0 = Mult, 1 = Div)
//             HI_Write, LO_Write     - HI/LO write enables (COMMIT cycle)
//             Busy                   - state is not IDLE
//             Done                   - commit pulse
//             Div_Zero               - divide-by-zero rejection pulse
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start_Mult,
    input  logic        Start_Div,
    input  logic [31:0] Divisor,
    input  logic        Abort,
    output logic        Mult_Control,
    output logic        Div_Control,
    output logic        HI_Src,
    output logic        LO_Src,
    output logic        HI_Write,
    output logic        LO_Write,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Zero
);

    localparam int               CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t r_state;
    logic   r_op;
    logic   r_mult_ctrl;
    logic   r_div_ctrl;
    logic   r_write;
    logic   r_busy;
    logic   r_done;
    logic   r_div_zero;

    logic             w_idle;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic             w_dec;
    logic             w_cnt_zero;

    assign w_idle       = (r_state == IDLE);
    // Counter is only loaded for starts that actually launch a unit.
    assign w_load       = w_idle && (Start_Mult || (Start_Div && (Divisor != '0)));
    assign w_load_value = Start_Mult ? MULT_LOAD : DIV_LOAD;
    assign w_dec        = (r_state == MULT_RUN) || (r_state == DIV_RUN);

    op_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk          (Clock),
        .rst          (Reset),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_dec        (w_dec),
        .o_zero       (w_cnt_zero)
    );

    // Outputs are registered alongside the state: each branch sets the
    // output values belonging to the state being entered, so every output
    // is a flop and Reset clears them asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_op        <= SRC_MULT;
            r_mult_ctrl <= 1'b0;
            r_div_ctrl  <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_mult_ctrl <= 1'b0;
            r_div_ctrl  <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Start_Mult wins; a simultaneous Start_Div is dropped.
                    if (Start_Mult) begin
                        r_state     <= MULT_RUN;
                        r_op        <= SRC_MULT;
                        r_mult_ctrl <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (Start_Div) begin
                        r_busy <= 1'b1;
                        if (Divisor != '0) begin
                            r_state    <= DIV_RUN;
                            r_op       <= SRC_DIV;
                            r_div_ctrl <= 1'b1;
                        end else begin
                            r_state    <= DZERO;
                            r_div_zero <= 1'b1;
                        end
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    if (Abort) begin
                        r_state <= IDLE;
                    end else if (w_cnt_zero) begin
                        r_state <= COMMIT;
                        r_write <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_mult_ctrl <= (r_state == MULT_RUN);
                        r_div_ctrl  <= (r_state == DIV_RUN);
                        r_busy      <= 1'b1;
                    end
                end
                // COMMIT and DZERO last one cycle; Abort makes no difference.
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Mult_Control = r_mult_ctrl;
    assign Div_Control  = r_div_ctrl;
    assign HI_Src       = r_op;
    assign LO_Src       = r_op;
    assign HI_Write     = r_write;
    assign LO_Write     = r_write;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Div_Zero     = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer (MULT=32, DIV=4).
//             Output vector order: {Mult_Control, Div_Control, HI_Src,
//             LO_Src, HI_Write, LO_Write, Busy, Done, Div_Zero}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int MC = 32;
    localparam int DC = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start_Mult = 1'b0;
    logic        Start_Div = 1'b0;
    logic [31:0] Divisor = '0;
    logic        Abort = 1'b0;
    logic        Mult_Control, Div_Control, HI_Src, LO_Src;
    logic        HI_Write, LO_Write, Busy, Done, Div_Zero;

    muldiv_sequencer #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start_Mult   (Start_Mult),
        .Start_Div    (Start_Div),
        .Divisor      (Divisor),
        .Abort        (Abort),
        .Mult_Control (Mult_Control),
        .Div_Control  (Div_Control),
        .HI_Src       (HI_Src),
        .LO_Src       (LO_Src),
        .HI_Write     (HI_Write),
        .LO_Write     (LO_Write),
        .Busy         (Busy),
        .Done         (Done),
        .Div_Zero     (Div_Zero)
    );

    always #5 Clock = ~Clock;

    logic [8:0] obs;
    assign obs = {Mult_Control, Div_Control, HI_Src, LO_Src,
                  HI_Write, LO_Write, Busy, Done, Div_Zero};

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: operation timeline ----------------
    // An accepted op started at edge m_s occupies cycles m_s .. m_s+N:
    // the first N run the unit, the last one commits.
    int m_mode = 0;      // 0 idle, 1 op in flight, 2 divide-by-zero pulse
    bit m_div  = 1'b0;   // last latched op (1 = divide)
    int m_s    = 0;
    int m_n    = 0;
    int cyc    = 0;

    task automatic model_edge(input bit sm, input bit sd, input logic [31:0] dv, input bit ab);
        case (m_mode)
            0: begin
                if (sm) begin
                    m_mode = 1; m_div = 1'b0; m_s = cyc; m_n = MC;
                end else if (sd) begin
                    if (dv != 0) begin
                        m_mode = 1; m_div = 1'b1; m_s = cyc; m_n = DC;
                    end else begin
                        m_mode = 2;
                    end
                end
            end
            1: if (ab || ((cyc - 1 - m_s) == m_n)) m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    function automatic logic [8:0] model_out();
        logic [8:0] o;
        o = {2'b00, m_div, m_div, 5'b0};
        if (m_mode == 1) begin
            if ((cyc - m_s) < m_n) begin
                o[8] = ~m_div;
                o[7] = m_div;
                o[2] = 1'b1;
            end else begin
                o[4:1] = 4'b1111;
            end
        end else if (m_mode == 2) begin
            o[2] = 1'b1;
            o[0] = 1'b1;
        end
        return o;
    endfunction

    // Drive inputs, take one edge, advance the model and compare.
    task automatic step(input bit sm, input bit sd, input logic [31:0] dv, input bit ab);
        Start_Mult = sm;
        Start_Div  = sd;
        Divisor    = dv;
        Abort      = ab;
        @(posedge Clock);
        #1;
        cyc++;
        model_edge(sm, sd, dv, ab);
        check("model", {23'b0, obs}, {23'b0, model_out()});
    endtask

    // After a multiply start: count run/busy/commit cycles over a window.
    task automatic count_mult(input string tag, input int sd_at);
        int mcnt, bcnt, commits;
        mcnt = 0; bcnt = 0; commits = 0;
        for (int i = 0; i < 40; i++) begin
            if (Mult_Control) mcnt++;
            if (Busy) bcnt++;
            if (Done) begin
                commits++;
                check({tag, "_commit"}, {28'b0, HI_Src, LO_Src, HI_Write, LO_Write}, 32'h3);
            end
            step(1'b0, (i == sd_at), 32'd9, 1'b0);
        end
        check({tag, "_mult_cycles"}, mcnt, MC);
        check({tag, "_busy_cycles"}, bcnt, MC + 1);
        check({tag, "_commits"}, commits, 1);
    endtask

    typedef struct packed {
        logic        sm;
        logic        sd;
        logic [31:0] dv;
        logic        ab;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_0_0_0_0_0_0_0}; // idle
        tbl[1]  = '{1'b0, 1'b1, 32'd7, 1'b0, 9'b0_1_1_1_0_0_1_0_0}; // div run 1
        tbl[2]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0};
        tbl[3]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0};
        tbl[4]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0}; // div run 4
        tbl[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_1_1_1_1_1_1_0}; // commit
        tbl[6]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_1_1_0_0_0_0_0}; // idle
        tbl[7]  = '{1'b0, 1'b1, 32'd0, 1'b0, 9'b0_0_1_1_0_0_1_0_1}; // div by zero
        tbl[8]  = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_1_1_0_0_0_0_0}; // idle again
        tbl[9]  = '{1'b1, 1'b1, 32'd5, 1'b0, 9'b1_0_0_0_0_0_1_0_0}; // mult wins
        tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 9'b0_0_0_0_0_0_0_0_0}; // abort
        tbl[11] = '{1'b0, 1'b1, 32'd3, 1'b0, 9'b0_1_1_1_0_0_1_0_0}; // div run 1
        tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0};
        tbl[13] = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0};
        tbl[14] = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_1_1_1_0_0_1_0_0};
        tbl[15] = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_1_1_1_1_1_1_0}; // commit
        tbl[16] = '{1'b0, 1'b0, 32'd0, 1'b0, 9'b0_0_1_1_0_0_0_0_0};

        // Reset state
        #1;
        check("reset_outputs", {23'b0, obs}, 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].sm, tbl[i].sd, tbl[i].dv, tbl[i].ab);
            check($sformatf("table_%0d", i), {23'b0, obs}, {23'b0, tbl[i].exp});
        end

        // Full multiply with both starts; a Start_Div at run cycle 5 is ignored
        step(1'b1, 1'b1, 32'd9, 1'b0);
        count_mult("mult_full", 4);

        // Abort at run cycle 10 of a multiply
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        check("pre_abort_run", {31'b0, Mult_Control}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("abort_drop", {30'b0, Mult_Control, Busy}, 32'd0);
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 40; i++) begin
                step(1'b0, 1'b0, 32'd0, 1'b0);
                if (Done || HI_Write) dones++;
            end
            check("abort_no_commit", dones, 0);
        end
        step(1'b1, 1'b0, 32'd0, 1'b0);
        count_mult("after_abort", -1);

        // Asynchronous reset mid-divide
        step(1'b0, 1'b1, 32'd11, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        #3;
        Reset = 1'b1;
        #1;
        check("async_reset", {23'b0, obs}, 32'h0);
        m_mode = 0;
        m_div  = 1'b0;
        @(posedge Clock);
        #1;
        check("reset_held", {23'b0, obs}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("idle_after_reset", {23'b0, obs}, 32'h0);

        // Randomized traffic against the timeline model
        for (int i = 0; i < 3000; i++) begin
            bit sm, sd, ab;
            logic [31:0] dv;
            sm = ($urandom_range(0, 19) == 0);
            sd = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 39) == 0);
            dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step(sm, sd, dv, ab);
        end

        Start_Mult = 1'b0;
        Start_Div  = 1'b0;
        Abort      = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
